// File: rtl/apb_completer_mem_if.sv
// APB4 completer-side bus bundle.
// Signals: psel, penable, pwrite, paddr, pwdata, pstrb (requester -> completer);
//          prdata, pready, pslverr (completer -> requester).
// Modports: master (requester side), slave (completer side).
interface apb_completer_mem_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_mem.sv
// APB4 completer with an internal word-addressed register memory, a fixed
// number of wait states per access, byte strobes and error signalling.
// Ports:
//   pclk      - clock, rising edge
//   presetn   - asynchronous active-low reset
//   bus       - APB completer bundle (slave modport): psel, penable, pwrite,
//               paddr (word index), pwdata, pstrb -> prdata, pready, pslverr
//   proto_err - sticky protocol-violation flag, cleared only by reset
module apb_completer_mem #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_completer_mem_if.slave   bus,
  output logic                 proto_err
);
  localparam int          IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NB     = DW / 8;
  localparam logic [3:0]  WAIT_L = 4'(WAIT);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            write_q;
  logic [IW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   strb_q;
  logic            err_q;
  logic [DW-1:0]   prdata_q;
  logic            pready_q;
  logic            pslverr_q;
  logic            proto_err_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            addr_err;
  logic [IW-1:0]   idx;

  assign addr_err = ({1'b0, bus.paddr} >= DEPTH_L);
  assign idx      = bus.paddr[IW-1:0];

  // pready/pslverr are registered one edge early so that they equal
  // (state==ACCESS && cnt==0) and (pready && err_q) from flops only.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      cnt         <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            state     <= ACCESS;
            write_q   <= bus.pwrite;
            addr_q    <= idx;
            wdata_q   <= bus.pwdata;
            strb_q    <= bus.pstrb;
            err_q     <= addr_err;
            cnt       <= WAIT_L;
            pready_q  <= (WAIT_L == 4'd0);
            pslverr_q <= (WAIT_L == 4'd0) && addr_err;
            if (!bus.pwrite) prdata_q <= addr_err ? '0 : mem[idx];
          end else if (bus.psel && bus.penable) begin
            proto_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus.psel && bus.penable) begin
            if (cnt != 4'd0) begin
              cnt       <= cnt - 4'd1;
              pready_q  <= (cnt == 4'd1);
              pslverr_q <= (cnt == 4'd1) && err_q;
            end else begin
              state     <= IDLE;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              if (write_q && !err_q) begin
                for (int unsigned b = 0; b < NB; b++) begin
                  if (strb_q[b]) mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
              end
            end
          end else begin
            state       <= IDLE;
            cnt         <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            proto_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: one instance with WAIT=1 and one with WAIT=0,
// driven from a shared set of requester signals gated by use_b. Stimulus
// pushes the expected response; a negedge monitor pops on every pready.
module tb_apb_completer_mem;
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        use_b = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        perr_a, perr_b;
  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m, perr_m;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 pclk = ~pclk;

  apb_completer_mem_if #(.AW(8), .DW(32)) if_a ();
  apb_completer_mem_if #(.AW(8), .DW(32)) if_b ();

  assign if_a.psel    = psel & ~use_b;
  assign if_a.penable = penable & ~use_b;
  assign if_b.psel    = psel & use_b;
  assign if_b.penable = penable & use_b;
  assign if_a.pwrite  = pwrite;
  assign if_b.pwrite  = pwrite;
  assign if_a.paddr   = paddr;
  assign if_b.paddr   = paddr;
  assign if_a.pwdata  = pwdata;
  assign if_b.pwdata  = pwdata;
  assign if_a.pstrb   = pstrb;
  assign if_b.pstrb   = pstrb;

  assign prdata_m  = use_b ? if_b.prdata  : if_a.prdata;
  assign pready_m  = use_b ? if_b.pready  : if_a.pready;
  assign pslverr_m = use_b ? if_b.pslverr : if_a.pslverr;
  assign perr_m    = use_b ? perr_b       : perr_a;

  apb_completer_mem #(.AW(8), .DW(32), .DEPTH(64), .WAIT(1)) dut_a (
    .pclk(pclk), .presetn(presetn), .bus(if_a.slave), .proto_err(perr_a)
  );
  apb_completer_mem #(.AW(8), .DW(32), .DEPTH(64), .WAIT(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .bus(if_b.slave), .proto_err(perr_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expectation.
  always @(negedge pclk) begin
    if (presetn && pready_m) begin
      if (sb.size() == 0) begin
        chk("unexpected_pready", 32'(pready_m), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pslverr", 32'(pslverr_m), 32'(e.err));
        if (e.is_read) chk("prdata", prdata_m, e.rdata);
      end
    end
  end

  task automatic idle();
    psel = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // One transfer; access-phase inputs are scrambled to show they are ignored.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_wait);
    exp_t e;
    int   n;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    e.is_read = !w; e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(posedge pclk); #1;
    penable = 1'b1;
    pwdata = ~d; paddr = a ^ 8'h01; pstrb = ~s;
    n = 0;
    while (!pready_m && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    if (!pready_m) chk("pready_timeout", 32'd0, 32'd1);
    chk("wait_cycles", 32'(n), 32'(exp_wait));
    @(posedge pclk); #1;
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_prdata", prdata_m, 32'h0);
    chk("rst_pready", 32'(pready_m), 32'd0);
    chk("rst_pslverr", 32'(pslverr_m), 32'd0);
    chk("rst_proto_err", 32'(perr_m), 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // WAIT=1 instance
    xfer(1'b0, 8'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1);
    xfer(1'b1, 8'd5, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 1);
    xfer(1'b0, 8'd5, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1);
    xfer(1'b1, 8'd63, 32'h12345678, 4'hF, 32'h0, 1'b0, 1);
    xfer(1'b0, 8'd63, 32'h0, 4'h0, 32'h12345678, 1'b0, 1);
    xfer(1'b1, 8'd64, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1);
    xfer(1'b0, 8'd64, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    xfer(1'b0, 8'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    idle();

    // WAIT=0 instance
    use_b = 1'b1;
    idle();
    xfer(1'b1, 8'd10, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
    xfer(1'b0, 8'd10, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);
    xfer(1'b1, 8'd10, 32'h0F0F0F0F, 4'b0110, 32'h0, 1'b0, 0);
    xfer(1'b0, 8'd10, 32'h0, 4'h0, 32'hA50F0FA5, 1'b0, 0);
    idle();
    chk("b_proto_err", 32'(perr_m), 32'd0);
    use_b = 1'b0;
    idle();

    // Abort in access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3;
    pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b1;
    @(posedge pclk); #1;
    chk("abort_proto_err", 32'(perr_m), 32'd1);
    chk("abort_pready", 32'(pready_m), 32'd0);
    idle();
    xfer(1'b0, 8'd3, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    xfer(1'b0, 8'd5, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1);
    idle();

    // Reset during the wait cycle of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    presetn = 1'b0;
    #1;
    chk("midrst_prdata", prdata_m, 32'h0);
    chk("midrst_pready", 32'(pready_m), 32'd0);
    chk("midrst_pslverr", 32'(pslverr_m), 32'd0);
    chk("midrst_proto_err", 32'(perr_m), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 8'd7, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    idle();
    chk("post_rst_proto_err", 32'(perr_m), 32'd0);

    // Access phase with no setup
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'd1;
    @(posedge pclk); #1;
    chk("nosetup_pready0", 32'(pready_m), 32'd0);
    @(posedge pclk); #1;
    chk("nosetup_pready1", 32'(pready_m), 32'd0);
    chk("nosetup_proto_err", 32'(perr_m), 32'd1);
    idle();
    idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/apb_completer_mem.md
# apb_completer_mem

APB4 completer (slave) with an internal word-addressed register memory, a programmable fixed wait-state count, byte strobes and error signalling. It is the responder side of the team's APB bridge: one instance sits behind each select line of the two-slave system, answering the setup/access transfers the requester drives and returning read data, `pready` and `pslverr`.

## Interface
- `AW`, 8: address width; `paddr` is a word index, not a byte address.
- `DW`, 32: data width; must be a multiple of 8.
- `DEPTH`, 64: number of implemented words, at most 2**AW.
- `WAIT`, 1: wait states inserted in every access phase, 0..15.

- `pclk`  in  1  clock; all logic is rising-edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `psel`  in  1  completer selected.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  AW  word address.
- `pwdata`  in  DW  write data.
- `pstrb`  in  DW/8  write byte strobes; bit i enables byte i.
- `prdata`  out  DW  read data; valid when `pready` is 1 for a read.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; valid only with `pready`.
- `proto_err`  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- The FSM has two states:
  - IDLE: no transfer in progress.
  - ACCESS: holds a 4-bit wait counter `cnt`.
- IDLE -> ACCESS on an edge sampling `psel`=1 and `penable`=0 (setup). On that edge the block captures:
  - `pwrite`, `paddr`, `pwdata`, `pstrb`;
  - the address error flag, `err_q = (paddr >= DEPTH)`;
  - `cnt = WAIT`;
  - for a read, `prdata` is loaded with `mem[paddr]`, or 0 when `err_q` is set.
- ACCESS, `cnt` != 0, `psel` and `penable` both 1: `cnt` decrements and the state stays ACCESS.
- ACCESS, `cnt` = 0, `psel` and `penable` both 1: this is the completion edge; the state returns to IDLE.
  - A write with `err_q`=0 updates `mem[addr]` only in the bytes whose captured strobe bit is set.
  - A write with `err_q`=1 changes no memory.
- ACCESS with `psel`=0 or `penable`=0 (requester abort): go to IDLE, perform no write, set `proto_err`.
- IDLE sampling `psel`=1 and `penable`=1 (access with no setup): stay IDLE, set `proto_err`, keep `pready`=0.
- Output decoding, all from flops with no combinational path from inputs:
  - `pready = (state==ACCESS && cnt==0)`;
  - `pslverr = pready && err_q`.
- `prdata` holds its last loaded value between transfers. It is not updated by writes.
- Signal changes during the access phase (`paddr`, `pwdata`, `pstrb`, `pwrite`) are ignored; the values captured at setup are used.
- Reads have no side effects.

## Timing
- Reset (asynchronous assertion, synchronous-safe release):
  - state = IDLE, `cnt` = 0;
  - `prdata` = 0, `pready` = 0, `pslverr` = 0, `proto_err` = 0;
  - all DEPTH memory words = 0.
- A transfer takes 2 + WAIT cycles: the setup cycle, then WAIT cycles with `pready`=0, then one cycle with `pready`=1.
- With WAIT=0, `pready` is 1 in the first access cycle.
- Write-then-read of the same address, back to back: the read returns the new data. The write commits on the completion edge, before the next setup edge.
- Back-to-back transfers: a setup sampled in the cycle after completion is accepted; the state is IDLE by then.
- Reset asserted mid-transfer: return to IDLE immediately. A write whose completion edge has not occurred has no effect.
- Address DEPTH-1 is valid; address DEPTH and above return `pslverr`=1 and `prdata`=0.

## Test plan
- Reset, then read address 0 with WAIT=1 -> `pready` is 1 in the 3rd cycle, `prdata`=0x00000000, `pslverr`=0.
- Write 0xDEADBEEF to address 5 with `pstrb`=4'b1111, then write 0x000000AA with `pstrb`=4'b0001, then read address 5 -> 0xDEADBEAA. Each transfer is 3 cycles, with no idle cycle between them.
- Write and read address 63 with data 0x12345678 -> read returns 0x12345678, `pslverr`=0. Write to address 64 -> `pslverr`=1 with `pready`; a following read of 64 gives `pslverr`=1 and `prdata`=0; address 0 remains unchanged.
- With WAIT=0: alternating write/read of 0xA5A5A5A5 at address 10 -> every transfer takes 2 cycles and `pready` is never low in the access phase.
- Abort: setup a write of 0x55 to address 3, then drop `psel` in the access phase -> `proto_err`=1 and address 3 still reads 0. Separately, drive `penable`=1 with no setup -> `pready` stays 0 and `proto_err`=1.
- Assert `presetn` during the wait cycle of a write of 0xFFFFFFFF to address 7 -> all outputs are 0; after release, address 7 reads 0 and `proto_err`=0.
